uart_rx: RTL

8N1 UART receiver, the receive-side counterpart of the board's UART transmit path. It synchronises the asynchronous UART_RX pin and finds the start bit. It samples each bit at mid-period using a baud counter derived from CLK_FREQ, then presents each received byte on a valid/ready output handshake. Framing errors and overruns are flagged as single-cycle pulses.

---
 rtl/uart_rx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 framing with a PARITY_ERR pulse output.
module uart_rx #(
    parameter int CLK_FREQ = 48_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       UART_RX,
    output logic [7:0] DATA,
    output logic       DATA_VALID,
    input  logic       DATA_READY,
    output logic       FRAMING_ERR,
`ifdef UART_RX_PARITY_EN
    output logic       PARITY_ERR,
`endif
    output logic       OVERRUN
);

    localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_data_valid;
    logic             r_framing_err;
    logic             r_overrun;
    logic             w_deliver_ok;
`ifdef UART_RX_PARITY_EN
    logic             r_parity_bit;
    logic             r_parity_err;
`endif

    // Both flops reset high so the line reads as idle straight out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= UART_RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    // A new byte may land if the slot is empty or is being consumed this cycle.
    assign w_deliver_ok = !r_data_valid || DATA_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit  <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err  <= 1'b0;
`endif
            r_cnt <= r_cnt + 1'b1;
            // NOTE: a later non-blocking assignment in this block wins, so a
            // delivery in S_STOP overrides this consume-side clear.
            if (r_data_valid && DATA_READY) begin
                r_data_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt        <= '0;
                        r_parity_bit <= r_rx_s;
                        r_state      <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            if (w_deliver_ok) begin
                                r_data       <= r_shift;
                                r_data_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= ^{r_shift, r_parity_bit};
`endif
                        end else begin
                            r_framing_err <= 1'b1;
                            r_state       <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // Holds off a break condition until the line returns high.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign DATA        = r_data;
    assign DATA_VALID  = r_data_valid;
    assign FRAMING_ERR = r_framing_err;
    assign OVERRUN     = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR  = r_parity_err;
`endif

endmodule
